// File: rtl/prog_loader.sv
// prog_loader: streams a program into CPU memory over valid/ready, holds the
// CPU in reset while loading, then releases it and counts run clocks until
// the CPU halts or the cycle limit is reached.
module prog_loader #(
   parameter int AWIDTH     = 5,
   parameter int DWIDTH     = 8,
   parameter int CWIDTH     = 16,
   parameter int MAX_CYCLES = 1023
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              start,
   input  logic [AWIDTH:0]   len_in,
   input  logic              in_valid,
   input  logic [DWIDTH-1:0] in_data,
   output logic              in_ready,
   output logic              mem_wr,
   output logic [AWIDTH-1:0] mem_addr,
   output logic [DWIDTH-1:0] mem_wdata,
   output logic              cpu_rst,
   input  logic              cpu_halt,
   output logic              busy,
   output logic              done,
   output logic              timeout,
   output logic [CWIDTH-1:0] cycles
);

   // Memory depth as a length value (2**AWIDTH); longer requests clamp to it.
   localparam logic [AWIDTH:0]   DEPTH = {1'b1, {AWIDTH{1'b0}}};
   localparam logic [CWIDTH-1:0] CMAX  = CWIDTH'(MAX_CYCLES);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LOAD = 3'd1,
      CRST = 3'd2,
      RUN  = 3'd3,
      DONE = 3'd4
   } state_t;

   state_t state;
   state_t next_state;

   // ptr is one bit wider than the address so it can reach DEPTH without wrapping.
   logic [AWIDTH:0] len_q;
   logic [AWIDTH:0] ptr;
   logic            accept;
   logic            start_ok;
   logic            last_beat;
   logic            limit_hit;

   // State register.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic and the outputs decoded directly from state.
   always_comb begin
      next_state = state;
      in_ready   = (state == LOAD);
      busy       = (state == LOAD) || (state == CRST) || (state == RUN);
      done       = (state == DONE);
      start_ok   = start && ((state == IDLE) || (state == DONE));
      accept     = in_valid && (state == LOAD);
      last_beat  = (ptr == (len_q - 1'b1));
      limit_hit  = (cycles >= (CMAX - 1'b1));
      case (state)
         IDLE, DONE: begin
            if (start) begin
               next_state = (len_in != '0) ? LOAD : CRST;
            end
         end
         LOAD: begin
            if (accept && last_beat) begin
               next_state = CRST;
            end
         end
         CRST: begin
            next_state = RUN;
         end
         RUN: begin
            if (cpu_halt || limit_hit) begin
               next_state = DONE;
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Registered outputs: write port, CPU reset, run counter and load pointer.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         mem_wr    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         cpu_rst   <= 1'b1;
         timeout   <= 1'b0;
         cycles    <= '0;
         len_q     <= '0;
         ptr       <= '0;
      end else begin
         mem_wr  <= accept;
         // CPU stays out of reset through DONE so a halted CPU remains frozen.
         cpu_rst <= !((next_state == RUN) || (next_state == DONE));
         if (accept) begin
            mem_addr  <= ptr[AWIDTH-1:0];
            mem_wdata <= in_data;
            ptr       <= ptr + 1'b1;
         end
         if (start_ok) begin
            len_q   <= (len_in > DEPTH) ? DEPTH : len_in;
            cycles  <= '0;
            timeout <= 1'b0;
            ptr     <= '0;
         end
         if ((state == RUN) && !cpu_halt) begin
            if (limit_hit) begin
               cycles  <= CMAX;
               timeout <= 1'b1;
            end else begin
               cycles <= cycles + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: a behavioural 8-cycle-per-instruction accumulator
// CPU sits on the memory/halt side, and an instruction-level reference model
// predicts the run length, timeout flag and memory writes.
`timescale 1ns/1ps
module tb_prog_loader;

   localparam int AW   = 5;
   localparam int DW   = 8;
   localparam int CW   = 16;
   localparam int MAXC = 1023;

   logic          clk = 1'b0;
   logic          rst_in;
   logic          start;
   logic [AW:0]   len_in;
   logic          in_valid;
   logic [DW-1:0] in_data;
   logic          in_ready;
   logic          mem_wr;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          cpu_rst;
   logic          cpu_halt;
   logic          busy;
   logic          done;
   logic          timeout;
   logic [CW-1:0] cycles;

   always #5 clk = ~clk;

   prog_loader #(.AWIDTH(AW), .DWIDTH(DW), .CWIDTH(CW), .MAX_CYCLES(MAXC)) dut (
      .clk_in(clk), .rst_in(rst_in), .start(start), .len_in(len_in),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .cpu_rst(cpu_rst), .cpu_halt(cpu_halt), .busy(busy), .done(done),
      .timeout(timeout), .cycles(cycles)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   // Physical program memory seen by the CPU, and the bench's own expectation of it.
   logic [7:0]  phys [32] = '{default: 8'h00};
   logic [7:0]  shadow [32];
   logic [12:0] exp_q [$];

   // Behavioural CPU: 8 clocks per instruction, HLT raises halt on its 4th clock.
   logic [4:0] cpu_pc;
   logic [7:0] cpu_acc;
   logic [2:0] cpu_ph;
   logic       cpu_halt_r;
   wire  [7:0] cpu_ir = phys[cpu_pc];
   assign cpu_halt = cpu_halt_r;

   always @(posedge clk) begin
      if (mem_wr) phys[mem_addr] <= mem_wdata;
      if (cpu_rst) begin
         cpu_pc     <= 5'd0;
         cpu_acc    <= 8'd0;
         cpu_ph     <= 3'd0;
         cpu_halt_r <= 1'b0;
      end else if (!cpu_halt_r) begin
         if (cpu_ph == 3'd3 && cpu_ir[7:5] == 3'd0) begin
            cpu_halt_r <= 1'b1;
         end else if (cpu_ph == 3'd7) begin
            cpu_ph <= 3'd0;
            cpu_pc <= cpu_pc + 5'd1;
            case (cpu_ir[7:5])
               3'd1: if (cpu_acc == 8'd0) cpu_pc <= cpu_pc + 5'd2;
               3'd2: cpu_acc <= cpu_acc + phys[cpu_ir[4:0]];
               3'd3: cpu_acc <= cpu_acc & phys[cpu_ir[4:0]];
               3'd4: cpu_acc <= cpu_acc ^ phys[cpu_ir[4:0]];
               3'd5: cpu_acc <= phys[cpu_ir[4:0]];
               3'd6: phys[cpu_ir[4:0]] <= cpu_acc;
               3'd7: cpu_pc <= cpu_ir[4:0];
               default: ;
            endcase
         end else begin
            cpu_ph <= cpu_ph + 3'd1;
         end
      end
   end

   // Write-port scoreboard: every strobe must match the next expected beat.
   always @(negedge clk) begin
      if (mem_wr) begin
         check("wr_pending", 32'(exp_q.size() != 0), 1);
         if (exp_q.size() != 0) begin
            logic [12:0] e;
            e = exp_q.pop_front();
            check("wr_addr", 32'(mem_addr), 32'(e[12:8]));
            check("wr_data", 32'(mem_wdata), 32'(e[7:0]));
         end
      end
   end

   // Instruction-level model: run length is 8 clocks per executed instruction
   // plus 4 for the HLT; anything reaching the limit is a timeout.
   task automatic model_run(output int ec, output bit eto);
      logic [4:0] pc;
      logic [7:0] acc;
      logic [7:0] ir;
      bit         fin;
      pc = 5'd0; acc = 8'd0; fin = 1'b0; ec = 0; eto = 1'b0;
      for (int n = 0; n < 200 && !fin; n++) begin
         ir = shadow[pc];
         if (ir[7:5] == 3'd0) begin
            if (8 * n + 4 >= MAXC) begin ec = MAXC; eto = 1'b1; end
            else ec = 8 * n + 4;
            fin = 1'b1;
         end else begin
            case (ir[7:5])
               3'd1: pc = pc + ((acc == 8'd0) ? 5'd2 : 5'd1);
               3'd2: begin acc = acc + shadow[ir[4:0]]; pc = pc + 5'd1; end
               3'd3: begin acc = acc & shadow[ir[4:0]]; pc = pc + 5'd1; end
               3'd4: begin acc = acc ^ shadow[ir[4:0]]; pc = pc + 5'd1; end
               3'd5: begin acc = shadow[ir[4:0]]; pc = pc + 5'd1; end
               3'd6: begin shadow[ir[4:0]] = acc; pc = pc + 5'd1; end
               default: pc = ir[4:0];
            endcase
            if (8 * (n + 1) + 4 >= MAXC) begin ec = MAXC; eto = 1'b1; fin = 1'b1; end
         end
      end
   endtask

   // Load a program (mode 0: always valid, 1: every other cycle, 2: random
   // valid), run it, and compare the result against the model.
   task automatic run_prog(input string name, input int len, input logic [7:0] prog[$],
                           input int mode, input bit poke, input int spec_cycles);
      int eff;
      int idx;
      int g;
      int ec;
      bit eto;
      bit v;
      eff = (len > 32) ? 32 : len;
      idx = 0;
      start = 1'b1; len_in = (AW+1)'(len);
      @(negedge clk);
      start = 1'b0;
      if (eff > 0) check({name, "_ready"}, 32'(in_ready), 1);
      g = 0;
      while (idx < eff && g < 400) begin
         case (mode)
            0:       v = 1'b1;
            1:       v = (g % 2 == 0);
            default: v = 1'($urandom_range(0, 1));
         endcase
         in_valid = v;
         in_data  = v ? prog[idx] : 8'($urandom);
         if (v && in_ready) begin
            exp_q.push_back({5'(idx), prog[idx]});
            shadow[idx] = prog[idx];
            idx++;
         end
         @(negedge clk);
         g++;
      end
      in_valid = 1'b0;
      check({name, "_beats"}, 32'(idx), 32'(eff));
      check({name, "_ready_off"}, 32'(in_ready), 0);
      model_run(ec, eto);
      g = 0;
      while (!done && g < 3000) begin
         if (poke && (g == 0 || g == 2)) begin
            start = 1'b1; len_in = (AW+1)'($urandom);
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         g++;
      end
      start = 1'b0;
      check({name, "_done"}, 32'(done), 1);
      check({name, "_cycles"}, 32'(cycles), 32'(ec));
      check({name, "_timeout"}, 32'(timeout), 32'(eto));
      check({name, "_cpu_rst"}, 32'(cpu_rst), 0);
      if (spec_cycles >= 0) check({name, "_cycles_ref"}, 32'(cycles), 32'(spec_cycles));
      repeat (3) @(negedge clk);
      check({name, "_hold"}, 32'(cycles), 32'(ec));
      check({name, "_drained"}, 32'(exp_q.size()), 0);
   endtask

   logic [7:0] p [$];
   logic [7:0] none [$];

   initial begin
      int idx;
      logic [2:0] op;
      int len;
      rst_in = 1'b1; start = 1'b0; len_in = '0; in_valid = 1'b0; in_data = '0;
      for (int i = 0; i < 32; i++) shadow[i] = 8'h00;
      repeat (3) @(negedge clk);
      check("rst_in_ready", 32'(in_ready), 0);
      check("rst_mem_wr", 32'(mem_wr), 0);
      check("rst_mem_addr", 32'(mem_addr), 0);
      check("rst_mem_wdata", 32'(mem_wdata), 0);
      check("rst_cpu_rst", 32'(cpu_rst), 1);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_timeout", 32'(timeout), 0);
      check("rst_cycles", 32'(cycles), 0);
      rst_in = 1'b0;
      @(negedge clk);
      check("idle_cpu_rst", 32'(cpu_rst), 1);

      p = '{8'h00};
      run_prog("hlt", 1, p, 0, 1'b0, 4);
      p = '{8'hE2, 8'hE2, 8'h00};
      run_prog("jmp", 3, p, 0, 1'b0, 12);
      p = '{8'h20, 8'hE2, 8'h00};
      run_prog("skz", 3, p, 1, 1'b0, 12);
      p = '{8'hA5, 8'h20, 8'h00, 8'hE4, 8'h00, 8'h01};
      run_prog("lda", 6, p, 1, 1'b0, 20);
      p = '{8'hE0};
      run_prog("loop", 1, p, 0, 1'b0, MAXC);
      p = '{8'h00};
      run_prog("hlt2", 1, p, 0, 1'b0, 4);
      run_prog("len0", 0, none, 0, 1'b1, 4);

      // Reset in the middle of a load: two beats written, then back to IDLE.
      p = '{8'hA5, 8'h20, 8'h00, 8'hE4, 8'h00, 8'h01};
      start = 1'b1; len_in = 6;
      @(negedge clk);
      start = 1'b0;
      idx = 0;
      while (idx < 2) begin
         check("rstld_ready", 32'(in_ready), 1);
         in_valid = 1'b1; in_data = p[idx];
         exp_q.push_back({5'(idx), p[idx]});
         shadow[idx] = p[idx];
         idx++;
         @(negedge clk);
      end
      in_valid = 1'b0; rst_in = 1'b1;
      @(negedge clk);
      rst_in = 1'b0;
      check("rstld_in_ready", 32'(in_ready), 0);
      check("rstld_cpu_rst", 32'(cpu_rst), 1);
      check("rstld_busy", 32'(busy), 0);
      check("rstld_mem_wr", 32'(mem_wr), 0);
      check("rstld_cycles", 32'(cycles), 0);
      check("rstld_drained", 32'(exp_q.size()), 0);

      p = '{8'hA7, 8'hC8, 8'hA8, 8'h20, 8'h00, 8'hE6, 8'h00, 8'h01, 8'h00};
      run_prog("sto", 9, p, 0, 1'b1, 36);

      // Random store-free programs with random valid gaps, some over-length.
      for (int r = 0; r < 5; r++) begin
         len = (r == 0) ? 45 : int'($urandom_range(1, 40));
         p.delete();
         for (int i = 0; i < 32; i++) begin
            op = 3'($urandom_range(0, 7));
            if (op == 3'd6) op = 3'd5;
            p.push_back({op, 5'($urandom)});
         end
         run_prog("rnd", len, p, 2, (r % 2 == 1), -1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "watchdog");
   end

endmodule
